// File: rtl/bn_pkg.sv
// Shared types, default widths and arithmetic helpers for the batch-norm stream.
package bn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int unsigned BN_DATA_W = 16;
  localparam int unsigned BN_COEF_W = 16;
  localparam int unsigned BN_FRAC_W = 12;
  localparam int unsigned PROD_W    = BN_DATA_W + BN_COEF_W;
  localparam int unsigned SUM_W     = PROD_W + 1;

  // Wide signed carrier so the helpers work for any configured width up to 63 bits.
  localparam int unsigned WIDE_W = 64;
  typedef logic signed [WIDE_W-1:0] wide_t;

  // Round half-up, then arithmetic shift right by frac (frac >= 1).
  function automatic wide_t round_shift(input wide_t p, input int unsigned frac);
    return (p + (wide_t'(1) <<< (frac - 1))) >>> frac;
  endfunction

  // Clamp s to the signed w-bit range; sat reports whether clamping happened.
  function automatic wide_t sat_clamp(input wide_t s, input int unsigned w, output logic sat);
    wide_t hi;
    wide_t lo;
    wide_t r;
    hi  = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    lo  = -(wide_t'(1) <<< (w - 1));
    r   = s;
    sat = 1'b0;
    if (s > hi) begin
      r   = hi;
      sat = 1'b1;
    end else if (s < lo) begin
      r   = lo;
      sat = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bn_lane.sv
// One scale/round/bias/saturate/ReLU lane: product registered, rest resolved combinationally.
module bn_lane import bn_pkg::*; #(
  parameter int unsigned DATA_W = BN_DATA_W,
  parameter int unsigned COEF_W = BN_COEF_W,
  parameter int unsigned FRAC_W = BN_FRAC_W,
  parameter int unsigned P_W    = PROD_W,
  parameter int unsigned S_W    = SUM_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_en,
  input  logic signed [DATA_W-1:0] i_x,
  input  logic signed [COEF_W-1:0] i_scale,
  input  logic signed [COEF_W-1:0] i_bias,
  input  logic                     i_relu,
  output logic signed [DATA_W-1:0] o_y_c,
  output logic                     o_sat_c
);

  logic signed [P_W-1:0] r_prod;
  logic signed [S_W-1:0] w_sum;
  wide_t                 w_rnd;
  wide_t                 w_clamp;
  logic                  w_sat;

  // Stage 1: capture the full-precision product of the issued element.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prod <= '0;
    end else if (i_en) begin
      r_prod <= P_W'(i_x) * P_W'(i_scale);
    end
  end

  // Stage 2: round, add bias, clamp, optional ReLU (result registered by the top).
  always_comb begin
    w_rnd   = round_shift(wide_t'(r_prod), FRAC_W);
    w_sum   = S_W'(w_rnd) + S_W'(i_bias);
    w_clamp = sat_clamp(wide_t'(w_sum), DATA_W, w_sat);
    o_sat_c = w_sat;
    o_y_c   = DATA_W'(w_clamp);
    if (i_relu && o_y_c[DATA_W-1]) begin
      o_y_c = '0;
    end
  end

endmodule

// File: rtl/batch_norm_stream.sv
// Folded batch-norm over a LEN-element vector, LANES elements per beat, with loadable coefficients.
module batch_norm_stream import bn_pkg::*; #(
  parameter int unsigned LEN      = 64,
  parameter int unsigned DATA_W   = BN_DATA_W,
  parameter int unsigned COEF_W   = BN_COEF_W,
  parameter int unsigned FRAC_W   = BN_FRAC_W,
  parameter int unsigned CHANNELS = 8,
  parameter int unsigned LANES    = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            valid_in,
  input  logic [LEN*DATA_W-1:0]           input_data,
  input  logic                            relu_en,
  output logic                            ready_out,
  output logic                            valid_out,
  input  logic                            out_ready,
  output logic [LEN*DATA_W-1:0]           output_data,
  output logic                            sat_flag,
  input  logic                            coef_we,
  // One spare code point so out-of-range channel indices are representable and rejectable.
  input  logic [$clog2(CHANNELS+1)-1:0]   coef_addr,
  input  logic signed [COEF_W-1:0]        coef_scale,
  input  logic signed [COEF_W-1:0]        coef_bias,
  output logic                            coef_err
);

  localparam int unsigned BEATS  = LEN / LANES;
  localparam int unsigned BEAT_W = $clog2(BEATS + 1);
  localparam int unsigned ADDR_W = $clog2(CHANNELS + 1);

  state_t                   r_state;
  state_t                   w_next;
  logic [BEAT_W-1:0]        r_beat;
  logic [BEAT_W-1:0]        r_s1_beat;
  logic                     r_s1_vld;
  logic [LEN*DATA_W-1:0]    r_x;
  logic                     r_relu;
  logic signed [COEF_W-1:0] r_scale [CHANNELS];
  logic signed [COEF_W-1:0] r_bias  [CHANNELS];

  logic                     w_accept;
  logic                     w_issue;
  logic                     w_last;
  logic                     w_coef_ok;
  logic signed [DATA_W-1:0] w_lx     [LANES];
  logic signed [DATA_W-1:0] w_ly     [LANES];
  logic signed [COEF_W-1:0] w_lscale [LANES];
  logic signed [COEF_W-1:0] w_lbias  [LANES];
  logic [LANES-1:0]         w_lsat;

  assign w_accept  = (r_state == ST_IDLE) && valid_in;
  assign w_issue   = (r_state == ST_RUN) && (r_beat < BEAT_W'(BEATS));
  assign w_last    = r_s1_vld && (r_s1_beat == BEAT_W'(BEATS - 1));
  assign w_coef_ok = coef_we && (r_state != ST_RUN) && (coef_addr < ADDR_W'(CHANNELS));

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (valid_in)  w_next = ST_RUN;
      ST_RUN:  if (w_last)    w_next = ST_DONE;
      ST_DONE: if (out_ready) w_next = ST_IDLE;
      default:                w_next = ST_IDLE;
    endcase
  end

  // State register with handshake outputs registered from the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      ready_out <= 1'b1;
      valid_out <= 1'b0;
    end else begin
      r_state   <= w_next;
      ready_out <= (w_next == ST_IDLE);
      valid_out <= (w_next == ST_DONE);
    end
  end

  // Lane operands: stage-1 element/scale from the issuing beat, stage-2 bias from the beat in flight.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      w_lx[l]     = '0;
      w_lscale[l] = '0;
      w_lbias[l]  = '0;
      for (int b = 0; b < BEATS; b++) begin
        if (r_beat == BEAT_W'(b)) begin
          w_lx[l]     = r_x[(b*LANES + l)*DATA_W +: DATA_W];
          w_lscale[l] = r_scale[(b*LANES + l) % CHANNELS];
        end
        if (r_s1_beat == BEAT_W'(b)) begin
          w_lbias[l]  = r_bias[(b*LANES + l) % CHANNELS];
        end
      end
    end
  end

  for (genvar gl = 0; gl < LANES; gl++) begin : g_lane
    bn_lane #(
      .DATA_W (DATA_W),
      .COEF_W (COEF_W),
      .FRAC_W (FRAC_W),
      .P_W    (DATA_W + COEF_W),
      .S_W    (DATA_W + COEF_W + 1)
    ) u_lane (
      .clk     (clk),
      .reset   (reset),
      .i_en    (w_issue),
      .i_x     (w_lx[gl]),
      .i_scale (w_lscale[gl]),
      .i_bias  (w_lbias[gl]),
      .i_relu  (r_relu),
      .o_y_c   (w_ly[gl]),
      .o_sat_c (w_lsat[gl])
    );
  end

  // Vector latch, beat sequencing and stage-2 writes into the output buffer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_x         <= '0;
      r_relu      <= 1'b0;
      r_beat      <= '0;
      r_s1_vld    <= 1'b0;
      r_s1_beat   <= '0;
      output_data <= '0;
      sat_flag    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_x         <= input_data;
        r_relu      <= relu_en;
        r_beat      <= '0;
        output_data <= '0;
        sat_flag    <= 1'b0;
      end else if (w_issue) begin
        r_beat <= r_beat + BEAT_W'(1);
      end
      r_s1_vld <= w_issue;
      if (w_issue) begin
        r_s1_beat <= r_beat;
      end
      if (r_s1_vld) begin
        for (int b = 0; b < BEATS; b++) begin
          if (r_s1_beat == BEAT_W'(b)) begin
            for (int l = 0; l < LANES; l++) begin
              output_data[(b*LANES + l)*DATA_W +: DATA_W] <= w_ly[l];
            end
          end
        end
        sat_flag <= sat_flag | (|w_lsat);
      end
    end
  end

  // Coefficient table: identity at reset, writes accepted only outside RUN and in range.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < CHANNELS; c++) begin
        r_scale[c] <= COEF_W'(1 << FRAC_W);
        r_bias[c]  <= '0;
      end
      coef_err <= 1'b0;
    end else begin
      coef_err <= coef_we && !w_coef_ok;
      for (int c = 0; c < CHANNELS; c++) begin
        if (w_coef_ok && (coef_addr == ADDR_W'(c))) begin
          r_scale[c] <= coef_scale;
          r_bias[c]  <= coef_bias;
        end
      end
    end
  end

endmodule

// File: tb/tb_batch_norm_stream.sv
// Directed-plus-random bench for batch_norm_stream against an arithmetic reference model.
module tb_batch_norm_stream;

  localparam int LEN = 64;
  localparam int DW  = 16;
  localparam int CH  = 8;
  localparam int AW  = 4;

  logic                 clk;
  logic                 reset;
  logic                 valid_in;
  logic [LEN*DW-1:0]    input_data;
  logic                 relu_en;
  logic                 ready_out;
  logic                 valid_out;
  logic                 out_ready;
  logic [LEN*DW-1:0]    output_data;
  logic                 sat_flag;
  logic                 coef_we;
  logic [AW-1:0]        coef_addr;
  logic signed [15:0]   coef_scale;
  logic signed [15:0]   coef_bias;
  logic                 coef_err;

  int     checks   = 0;
  int     failures = 0;
  int     xv [LEN];
  longint ev [LEN];
  bit     esat;
  logic [LEN*DW-1:0] evec;
  longint m_scale [CH];
  longint m_bias  [CH];

  batch_norm_stream dut (
    .clk         (clk),
    .reset       (reset),
    .valid_in    (valid_in),
    .input_data  (input_data),
    .relu_en     (relu_en),
    .ready_out   (ready_out),
    .valid_out   (valid_out),
    .out_ready   (out_ready),
    .output_data (output_data),
    .sat_flag    (sat_flag),
    .coef_we     (coef_we),
    .coef_addr   (coef_addr),
    .coef_scale  (coef_scale),
    .coef_bias   (coef_bias),
    .coef_err    (coef_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic logic signed [63:0] elem_of(input int i);
    logic signed [DW-1:0] t;
    t = output_data[i*DW +: DW];
    return 64'(t);
  endfunction

  // y = clamp(floor((x*s + 2048) / 4096) + b), then ReLU.
  function automatic longint bn_ref(input longint x, input longint s, input longint b,
                                    input bit relu, output bit sat);
    longint t, q, y;
    t = x * s + 2048;
    q = t / 4096;
    if ((t % 4096 != 0) && (t < 0)) q = q - 1;
    y   = q + b;
    sat = 1'b0;
    if (y > 32767) begin y = 32767; sat = 1'b1; end
    else if (y < -32768) begin y = -32768; sat = 1'b1; end
    if (relu && y < 0) y = 0;
    return y;
  endfunction

  task automatic model_identity();
    for (int c = 0; c < CH; c++) begin
      m_scale[c] = 4096;
      m_bias[c]  = 0;
    end
  endtask

  task automatic load(input int c, input longint s, input longint b);
    coef_we    = 1'b1;
    coef_addr  = AW'(c);
    coef_scale = 16'(s);
    coef_bias  = 16'(b);
    @(posedge clk); #1;
    coef_we = 1'b0;
    check($sformatf("coef_ok_%0d", c), 64'(coef_err), 0);
    m_scale[c] = s;
    m_bias[c]  = b;
  endtask

  task automatic load_all(input longint s, input longint b);
    for (int c = 0; c < CH; c++) load(c, s, b);
  endtask

  task automatic fill_random();
    for (int i = 0; i < LEN; i++) xv[i] = int'($urandom_range(0, 65535)) - 32768;
  endtask

  task automatic expect_vec(input bit relu);
    bit s;
    esat = 1'b0;
    for (int i = 0; i < LEN; i++) begin
      ev[i] = bn_ref(longint'(xv[i]), m_scale[i % CH], m_bias[i % CH], relu, s);
      esat  = esat | s;
      evec[i*DW +: DW] = DW'(ev[i]);
    end
  endtask

  task automatic drive_vec();
    for (int i = 0; i < LEN; i++) input_data[i*DW +: DW] = DW'(xv[i]);
  endtask

  // Accept one vector, then count edges until valid_out (bounded).
  task automatic send_and_wait(input bit relu, input bit toggle, input string tag);
    int lat;
    expect_vec(relu);
    drive_vec();
    check({tag, "_rdy_pre"}, 64'(ready_out), 1);
    relu_en  = relu;
    valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    check({tag, "_rdy_busy"}, 64'(ready_out), 0);
    lat = 0;
    while (!valid_out && lat < 40) begin
      if (toggle) relu_en = ~relu_en;
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 9);
  endtask

  task automatic check_vec(input string tag);
    for (int i = 0; i < LEN; i++) check($sformatf("%s_y%0d", tag, i), elem_of(i), 64'(ev[i]));
    check({tag, "_sat"}, 64'(sat_flag), 64'(esat));
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_vout_drop"}, 64'(valid_out), 0);
    check({tag, "_rdy_back"}, 64'(ready_out), 1);
  endtask

  initial begin
    int lat;
    reset = 1'b0; valid_in = 1'b0; input_data = '0; relu_en = 1'b0; out_ready = 1'b0;
    coef_we = 1'b0; coef_addr = '0; coef_scale = '0; coef_bias = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 64'(ready_out), 1);
    check("rst_valid", 64'(valid_out), 0);
    check("rst_sat", 64'(sat_flag), 0);
    check("rst_coef_err", 64'(coef_err), 0);
    check("rst_data_zero", 64'(output_data == '0), 1);
    reset = 1'b1;
    model_identity();
    @(posedge clk); #1;

    // Identity table after reset
    fill_random(); xv[0] = 302; xv[1] = -256; xv[63] = 39;
    send_and_wait(1'b0, 1'b0, "t1");
    check_vec("t1");
    check("t1_x0", elem_of(0), 302);
    check("t1_x1", elem_of(1), -256);
    check("t1_x63", elem_of(63), 39);
    check("t1_nosat", 64'(sat_flag), 0);
    consume("t1");

    // Half scale with bias
    load_all(2048, 10);
    fill_random(); xv[0] = 302; xv[9] = -7; xv[1] = -256;
    send_and_wait(1'b0, 1'b0, "t2");
    check_vec("t2");
    check("t2_x0", elem_of(0), 161);
    check("t2_x9", elem_of(9), 7);
    check("t2_x1", elem_of(1), -118);
    consume("t2");

    // Saturation at scale 4.0
    load_all(16384, 0);
    fill_random(); xv[0] = 32000; xv[1] = -32000; xv[2] = 100;
    send_and_wait(1'b0, 1'b0, "t3");
    check_vec("t3");
    check("t3_hi", elem_of(0), 32767);
    check("t3_lo", elem_of(1), -32768);
    check("t3_mid", elem_of(2), 400);
    check("t3_sat", 64'(sat_flag), 1);
    consume("t3");

    // ReLU latched at accept, toggled during RUN
    load_all(4096, 0);
    fill_random(); xv[0] = -256; xv[1] = 302;
    send_and_wait(1'b1, 1'b1, "t4");
    check_vec("t4");
    check("t4_neg", elem_of(0), 0);
    check("t4_pos", elem_of(1), 302);
    consume("t4");
    relu_en = 1'b0;

    // Random per-channel coefficients with backpressure and ignored valid_in
    for (int c = 0; c < CH; c++)
      load(c, longint'($urandom_range(0, 32767)) - 16384, longint'($urandom_range(0, 4095)) - 2048);
    fill_random();
    send_and_wait(1'b0, 1'b0, "t5");
    check_vec("t5");
    for (int k = 0; k < 20; k++) begin
      valid_in = 1'b1;
      for (int i = 0; i < LEN; i++) input_data[i*DW +: DW] = DW'($urandom_range(0, 65535));
      @(posedge clk); #1;
      check($sformatf("t5_hold_vout%0d", k), 64'(valid_out), 1);
      check($sformatf("t5_hold_rdy%0d", k), 64'(ready_out), 0);
      check($sformatf("t5_hold_data%0d", k), 64'(output_data == evec), 1);
      check($sformatf("t5_hold_sat%0d", k), 64'(sat_flag), 64'(esat));
    end
    valid_in = 1'b0;
    consume("t5");

    // Coefficient write during RUN is rejected
    fill_random();
    expect_vec(1'b0);
    drive_vec();
    valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    coef_we = 1'b1; coef_addr = AW'(0); coef_scale = 16'sd1234; coef_bias = 16'sd55;
    @(posedge clk); #1;
    coef_we = 1'b0;
    check("t6_err_run", 64'(coef_err), 1);
    @(posedge clk); #1;
    check("t6_err_pulse", 64'(coef_err), 0);
    lat = 2;
    while (!valid_out && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("t6_latency", 64'(lat), 9);
    check_vec("t6");
    consume("t6");

    // Out-of-range channel index is rejected in IDLE
    coef_we = 1'b1; coef_addr = AW'(8); coef_scale = 16'sd777; coef_bias = 16'sd99;
    @(posedge clk); #1;
    coef_we = 1'b0;
    check("t6_err_addr", 64'(coef_err), 1);
    @(posedge clk); #1;
    check("t6_err_addr_pulse", 64'(coef_err), 0);
    fill_random();
    send_and_wait(1'b0, 1'b0, "t6b");
    check_vec("t6b");
    consume("t6b");

    // Reset in the middle of RUN
    fill_random(); drive_vec();
    valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("t7_rst_ready", 64'(ready_out), 1);
    check("t7_rst_valid", 64'(valid_out), 0);
    check("t7_rst_sat", 64'(sat_flag), 0);
    check("t7_rst_err", 64'(coef_err), 0);
    check("t7_rst_data", 64'(output_data == '0), 1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    model_identity();
    fill_random();
    send_and_wait(1'b0, 1'b0, "t7");
    check_vec("t7");
    consume("t7");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
